id_check_stream: RTL

Parametrised streaming national-ID checker, successor to the fixed-length ID checker. It accepts one symbol per cycle: a letter code followed by BODY_DIGITS decimal digits and, in verify mode, a check digit. It computes the weighted mod-10 checksum on the fly and reports legality, or generates the check digit. It sits between the ID input deserialiser and the record-validation stage, and accepts back-to-back IDs with no idle cycle.

---
 rtl/id_check_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/id_check_stream.sv
// Streaming national-ID checker: letter code + BODY_DIGITS digits (+ check digit in
// verify mode), weighted mod-10 checksum accumulated one symbol per cycle.
module id_check_stream #(
  parameter int BODY_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] in_id,
  input  logic       in_mode,
  output logic       out_valid,
  output logic       out_legal_id,
  output logic [3:0] out_check,
  output logic       out_err
);

  typedef enum logic [1:0] {IDLE, BODY, CHK} state_e;

  localparam logic [3:0] LAST = 4'(BODY_DIGITS - 1);
  localparam logic [7:0] UW   = 8'(BODY_DIGITS + 1);

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d, cnt_q, cnt_d;
  logic       mode_q, mode_d, err_q, err_d;
  logic       vld_q, vld_d, legal_q, legal_d, oerr_q, oerr_d;
  logic [3:0] chk_q, chk_d;

  logic       let_bad, dig_bad, err_n;
  logic [3:0] dig, t, u, wgt;
  logic [7:0] sum;

  function automatic logic [3:0] mod10(input logic [7:0] v);
    return 4'(v % 8'd10);
  endfunction

  // Out-of-range symbols contribute zero so the product never exceeds 8 bits;
  // the sticky error flag already condemns the frame.
  assign let_bad = (in_id < 6'd10) || (in_id > 6'd35);
  assign dig_bad = in_id > 6'd9;
  assign dig     = dig_bad ? 4'd0 : in_id[3:0];
  assign t       = let_bad ? 4'd0 : 4'(in_id / 6'd10);
  assign u       = let_bad ? 4'd0 : 4'(in_id % 6'd10);
  assign wgt     = 4'(BODY_DIGITS) - cnt_q;
  assign sum     = 8'(acc_q) + 8'(dig) * 8'(wgt);
  assign err_n   = err_q | dig_bad;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    legal_d = 1'b0;
    chk_d   = 4'd0;
    oerr_d  = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        mode_d  = in_mode;
        err_d   = let_bad;
        acc_d   = mod10(8'(t) + 8'(u) * UW);
        cnt_d   = 4'd0;
        state_d = BODY;
      end
      BODY: if (!in_valid) begin
        state_d = IDLE;
        err_d   = 1'b0;
        vld_d   = 1'b1;
        oerr_d  = 1'b1;
      end else begin
        acc_d = mod10(sum);
        err_d = err_n;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          if (mode_q) begin
            state_d = IDLE;
            vld_d   = 1'b1;
            oerr_d  = err_n;
            legal_d = !err_n;
            chk_d   = err_n ? 4'd0 : mod10(8'd10 - 8'(acc_d));
          end else begin
            state_d = CHK;
          end
        end
      end
      CHK: if (!in_valid) begin
        state_d = IDLE;
        err_d   = 1'b0;
        vld_d   = 1'b1;
        oerr_d  = 1'b1;
      end else begin
        state_d = IDLE;
        err_d   = 1'b0;
        vld_d   = 1'b1;
        oerr_d  = err_n;
        legal_d = !err_n && (mod10(8'(acc_q) + 8'(dig)) == 4'd0);
        chk_d   = err_n ? 4'd0 : mod10(8'd10 - 8'(acc_q));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 4'd0;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      legal_q <= 1'b0;
      chk_q   <= 4'd0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      legal_q <= legal_d;
      chk_q   <= chk_d;
      oerr_q  <= oerr_d;
    end
  end

  assign out_valid    = vld_q;
  assign out_legal_id = legal_q;
  assign out_check    = chk_q;
  assign out_err      = oerr_q;

endmodule
